uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares the single transmitter of `UART_System` between NREQ byte requesters. After reset it enables the UART by writing the control register once. It then repeatedly picks one pending requester, issues `tx_start` with that requester's byte and waits for `tx_done`. It sits between client logic and the `UART_System` `wr_en/control_data/tx_start/tx_data/tx_done` ports.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `CTRL_INIT`, 8'h03: value written to the UART control register after reset (bit0 TX enable, bit1 RX enable).
- `TIMEOUT`, 2048: max cycles in WAIT before abandoning a transfer; ≥ 16.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low (logic 0 resets on a rising `clk` edge).
- `req` in NREQ: level request per requester; held until that requester's `grant`.
- `req_data` in 8*NREQ: byte for requester i is `req_data[8i+7:8i]`; must be stable while `req[i]` = 1.
- `grant` out NREQ: one-hot, one-cycle pulse; the byte of that requester has been captured.
- `done` out NREQ: one-hot, one-cycle pulse; that requester's byte finished transmitting.
- `err` out 1: one-cycle pulse on a WAIT timeout.
- `busy` out 1: 1 in every state except IDLE.
- `cur_id` out 3: index of the requester last granted.
- `wr_en` out 1: UART control-register write strobe.
- `control_data` out 8: UART control-register value.
- `tx_start` out 1: one-cycle UART start pulse.
- `tx_data` out 8: byte presented to the UART; held from grant until the transfer leaves WAIT.
- `tx_done` in 1: UART completion; only its rising edge is used.

## Operation
- States:
  - INIT: `wr_en`=1, `control_data`=CTRL_INIT for exactly one cycle, then IDLE.
  - IDLE: if `req` ≠ 0, select the winner, register it into `cur_id`/`tx_data`, pulse `grant`, go to START. Otherwise stay in IDLE.
  - START: `tx_start`=1 for one cycle, clear the watchdog, go to WAIT.
  - WAIT: increment the watchdog. On a `tx_done` rising edge, pulse `done[cur_id]` and go to IDLE. If the watchdog reaches TIMEOUT−1, pulse `err` and go to IDLE with no `done`.
- Arbitration: round-robin from pointer `ptr`. Search starts at `ptr` and wraps modulo NREQ; the first set `req` bit wins.
- `ptr` update: `ptr` ← `cur_id`+1 (mod NREQ) on leaving WAIT, for both done and timeout. This wrap applies even when NREQ is not a power of two.
- Reset value of `ptr` is 0.
- `tx_done` edge detect: register `tx_done_q`; edge = `tx_done & ~tx_done_q`. `tx_done_q` updates in every state, so a level still high from a previous byte is not counted as a new completion.
- A requester that drops `req` before it is granted is simply skipped; no state is kept per requester.
- Requests raised while the scheduler is busy wait until the next IDLE.
- `control_data` holds CTRL_INIT after INIT. It is never rewritten except by a reset.

## Timing
- Reset values: state=INIT, `grant`=0, `done`=0, `err`=0, `tx_start`=0, `wr_en`=0, `control_data`=0, `tx_data`=0, `cur_id`=0, `busy`=1, `ptr`=0.
- First cycle after `rst` goes high: `wr_en`=1. The next cycle is IDLE.
- Latency: `req` seen in IDLE at edge N → `grant` high in cycle N+1 → `tx_start` high in cycle N+2.
- Minimum gap from a `done` pulse to the next `grant` is 1 cycle (one IDLE cycle).
- A `tx_done` edge arriving in START or IDLE is ignored; only WAIT consumes it.
- If the edge and the timeout occur in the same cycle, the edge wins: `done` pulses and `err` does not.
- All outputs are registered; there are no combinational paths from `req` or `tx_done` to any output.
- Reset asserted mid-transfer: on the next edge every output returns to its reset value, and the sequence restarts at INIT, including the control write.

## Test plan
- Reset release, no requests → exactly one cycle of `wr_en`=1 with `control_data`=8'h03; afterwards `busy`=0 and `tx_start` never pulses.
- Loopback through `UART_System`, `req`=4'b0001, byte 8'hA5 → `grant`=0001, `tx_start` one cycle later, `done`=0001 after `tx_done`, and RX sees 8'hA5.
- All four requests held, bytes 8'h11/22/33/44 → grants arrive in order 0,1,2,3; a second round starts again at 0; each byte is received intact.
- `ptr`=2 (after servicing requester 1) with `req`=4'b0011 → requester 0 wins via wrap-around, then requester 1.
- `tx_done` tied low, TIMEOUT=16 → `err` pulses 16 cycles after `tx_start`, no `done`, the scheduler returns to IDLE and `ptr` advances.
- `rst` pulled low during WAIT → all outputs reach their reset values on the next edge, then INIT repeats the 8'h03 write; a pending request is re-granted afterwards.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//
// Shares the single transmitter of UART_System between NREQ byte
// requesters using round-robin arbitration. After reset the UART control
// register is written once with CTRL_INIT. Afterwards the block
// repeatedly grants one pending requester, starts the UART with that
// requester's byte, and waits for the UART to report completion.
//
// Handshake: req[i] is a level held by requester i until it sees
// grant[i] (a one-cycle pulse meaning "your byte has been captured").
// done[i] pulses once that byte has finished transmitting. err pulses
// instead of done if the UART never reports completion within TIMEOUT
// cycles.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous reset, active low
//   req           per-requester request level
//   req_data      byte of requester i at [8i+7:8i]
//   grant         one-hot capture pulse
//   done          one-hot completion pulse
//   err           watchdog timeout pulse
//   busy          high in every state except IDLE
//   cur_id        index of the requester last granted
//   wr_en         UART control-register write strobe
//   control_data  UART control-register value
//   tx_start      one-cycle UART start pulse
//   tx_data       byte presented to the UART
//   tx_done       UART completion (rising edge used)
//   dbg_state     current FSM state for observation
//
// Every output comes straight from a flop (busy and dbg_state decode
// only the state register), so there is no path from req or tx_done to
// an output.

module uart_tx_scheduler #(
    parameter int         NREQ      = 4,
    parameter logic [7:0] CTRL_INIT = 8'h03,
    parameter int         TIMEOUT   = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic              busy,
    output logic [2:0]        cur_id,
    output logic              wr_en,
    output logic [7:0]        control_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    output logic [1:0]        dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              err_q, err_d;
    logic              tx_start_q, tx_start_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        control_data_q, control_data_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [2:0]        cur_id_q, cur_id_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              tx_done_q, tx_done_d;

    // Arbiter results
    logic [7:0]        req_ext;
    logic [63:0]       req_data_ext;
    logic [3:0]        idx;
    logic              found;
    logic [2:0]        win_id;
    logic [7:0]        win_byte;
    logic [2:0]        next_ptr;
    logic              tx_edge;

    // Round-robin search starting at ptr_q. ptr_q is always < NREQ, so a
    // single conditional subtraction gives the wrap for any NREQ, power of
    // two or not. Inputs are zero-padded to 8 requesters so the 3-bit
    // index never exceeds the vector.
    always_comb begin
        req_ext      = 8'(req);
        req_data_ext = 64'(req_data);
        idx          = '0;
        found        = 1'b0;
        win_id       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = 4'(ptr_q) + 4'(i);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            if (!found && req_ext[idx[2:0]]) begin
                found  = 1'b1;
                win_id = idx[2:0];
            end
        end
        win_byte = req_data_ext[{win_id, 3'b000} +: 8];
    end

    assign next_ptr = (cur_id_q == 3'(NREQ - 1)) ? 3'd0 : cur_id_q + 3'd1;

    // tx_done_q follows tx_done in every state, so a level left high from
    // the previous byte never looks like a fresh completion in WAIT.
    assign tx_edge   = tx_done & ~tx_done_q;
    assign tx_done_d = tx_done;

    always_comb begin
        state_d        = state_q;
        grant_d        = '0;
        done_d         = '0;
        err_d          = 1'b0;
        tx_start_d     = 1'b0;
        wr_en_d        = 1'b0;
        control_data_d = control_data_q;
        tx_data_d      = tx_data_q;
        cur_id_d       = cur_id_q;
        ptr_d          = ptr_q;
        wd_d           = wd_q;

        unique case (state_q)
            S_INIT: begin
                // First INIT cycle raises the write strobe; the cycle in
                // which the strobe is visible moves on to IDLE.
                if (!wr_en_q) begin
                    wr_en_d        = 1'b1;
                    control_data_d = CTRL_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (found) begin
                    cur_id_d  = win_id;
                    tx_data_d = win_byte;
                    for (int i = 0; i < NREQ; i++) begin
                        grant_d[i] = (win_id == 3'(i));
                    end
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_start_d = 1'b1;
                wd_d       = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                // Completion is checked first so it beats a same-cycle timeout.
                if (tx_edge) begin
                    for (int i = 0; i < NREQ; i++) begin
                        done_d[i] = (cur_id_q == 3'(i));
                    end
                    ptr_d   = next_ptr;
                    state_d = S_IDLE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    ptr_d   = next_ptr;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_INIT;
            grant_q        <= '0;
            done_q         <= '0;
            err_q          <= 1'b0;
            tx_start_q     <= 1'b0;
            wr_en_q        <= 1'b0;
            control_data_q <= '0;
            tx_data_q      <= '0;
            cur_id_q       <= '0;
            ptr_q          <= '0;
            wd_q           <= '0;
            tx_done_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            done_q         <= done_d;
            err_q          <= err_d;
            tx_start_q     <= tx_start_d;
            wr_en_q        <= wr_en_d;
            control_data_q <= control_data_d;
            tx_data_q      <= tx_data_d;
            cur_id_q       <= cur_id_d;
            ptr_q          <= ptr_d;
            wd_q           <= wd_d;
            tx_done_q      <= tx_done_d;
        end
    end

    assign grant        = grant_q;
    assign done         = done_q;
    assign err          = err_q;
    assign busy         = (state_q != S_IDLE);
    assign cur_id       = cur_id_q;
    assign wr_en        = wr_en_q;
    assign control_data = control_data_q;
    assign tx_start     = tx_start_q;
    assign tx_data      = tx_data_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: a behavioural UART answers tx_start
// with a delayed tx_done pulse and records every byte it is handed.
// Expected (requester, byte) pairs are queued in round-robin order when
// requests are driven and compared as grants, bytes and completions come
// out of the design.

module tb_uart_tx_scheduler;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        err;
    logic        busy;
    logic [2:0]  cur_id;
    logic        wr_en;
    logic [7:0]  control_data;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NREQ      (NREQ),
        .CTRL_INIT (8'h03),
        .TIMEOUT   (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .grant        (grant),
        .done         (done),
        .err          (err),
        .busy         (busy),
        .cur_id       (cur_id),
        .wr_en        (wr_en),
        .control_data (control_data),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [10:0] exp_q[$];   // {id[2:0], byte[7:0]}
    logic [7:0]  rx_q[$];
    int          model_ptr = 0;

    // ---------------- behavioural UART ----------------
    int uart_cnt   = 0;
    int hold_cnt   = 0;
    int last_delay = 0;
    bit uart_mute  = 1'b0;

    // tx_done rises 2..6 cycles after tx_start and stays high 4 cycles, so
    // its level is still high when the next transfer enters WAIT.
    always @(negedge clk) begin
        if (!rst) begin
            uart_cnt = 0;
            hold_cnt = 0;
            tx_done  = 1'b0;
        end else begin
            if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) tx_done = 1'b0;
            end
            if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    tx_done  = 1'b1;
                    hold_cnt = 4;
                end
            end
            if (tx_start) begin
                rx_q.push_back(tx_data);
                if (!uart_mute) begin
                    last_delay = $urandom_range(2, 6);
                    uart_cnt   = last_delay;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Queue the expected service order for a set of requests raised together.
    task automatic push_round(input logic [3:0] mask);
        for (int k = 0; k < NREQ; k++) begin
            automatic int id = (model_ptr + k) % NREQ;
            if (mask[id]) exp_q.push_back({3'(id), req_data[id*8 +: 8]});
        end
    endtask

    // Service the next expected transfer end to end.
    task automatic serve_one(input bit expect_timeout);
        logic [10:0] e;
        logic [2:0]  eid;
        logic [7:0]  eb;
        logic [3:0]  g;
        int          n;
        check_eq("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e   = exp_q.pop_front();
        eid = e[10:8];
        eb  = e[7:0];

        n = 0;
        while (grant == '0 && n < 60) begin
            tick();
            n++;
        end
        check_eq("grant_seen", 32'(grant != '0), 32'd1);
        g = grant;
        check_eq("grant_id", 32'(grant), 32'(4'b0001 << eid));
        check_eq("cur_id", 32'(cur_id), 32'(eid));
        check_eq("tx_data_at_grant", 32'(tx_data), 32'(eb));
        check_eq("busy_granted", 32'(busy), 32'd1);
        req = req & ~g;

        tick();
        check_eq("tx_start", 32'(tx_start), 32'd1);
        check_eq("grant_one_cycle", 32'(grant), 32'd0);

        n = 0;
        while (done == '0 && !err && n < 200) begin
            tick();
            n++;
        end
        if (!expect_timeout) begin
            check_eq("done_id", 32'(done), 32'(4'b0001 << eid));
            check_eq("done_latency", 32'(n), 32'(last_delay + 1));
            check_eq("err_low", 32'(err), 32'd0);
        end else begin
            check_eq("err_pulse", 32'(err), 32'd1);
            check_eq("err_latency", 32'(n), 32'(TMO));
            check_eq("no_done", 32'(done), 32'd0);
        end
        check_eq("busy_after", 32'(busy), 32'd0);
        check_eq("rx_nonempty", 32'(rx_q.size() != 0), 32'd1);
        if (rx_q.size() != 0) check_eq("rx_byte", 32'(rx_q.pop_front()), 32'(eb));
        model_ptr = (int'(eid) + 1) % NREQ;

        tick();
        check_eq("done_err_one_cycle", 32'({done, err}), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_grant"}, 32'(grant), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check_eq({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check_eq({tag, "_control_data"}, 32'(control_data), 32'd0);
        check_eq({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check_eq({tag, "_cur_id"}, 32'(cur_id), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    task automatic check_init_write(input string tag);
        check_eq({tag, "_wr_en_high"}, 32'(wr_en), 32'd1);
        check_eq({tag, "_ctrl_value"}, 32'(control_data), 32'h03);
        tick();
        check_eq({tag, "_wr_en_low"}, 32'(wr_en), 32'd0);
        check_eq({tag, "_ctrl_held"}, 32'(control_data), 32'h03);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish at %0t", $time);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int starts;
        logic [3:0] mask;

        // Reset and control write, no requests.
        rst = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
        check_eq("init_busy", 32'(busy), 32'd1);
        check_init_write("init");
        starts = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_start) starts++;
            if (wr_en) starts += 100;
        end
        check_eq("idle_quiet", 32'(starts), 32'd0);

        // All four requesters, two rounds.
        for (int r = 0; r < 2; r++) begin
            req_data = 32'h4433_2211;
            req      = 4'b1111;
            push_round(4'b1111);
            for (int k = 0; k < 4; k++) serve_one(1'b0);
        end

        // Single request from requester 0.
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        push_round(4'b0001);
        serve_one(1'b0);

        // Requester 1, leaving the pointer at 2.
        req_data[15:8] = 8'h7E;
        req = 4'b0010;
        push_round(4'b0010);
        serve_one(1'b0);

        // Wrap-around: requesters 0 and 1 from pointer 2.
        req_data[15:0] = 16'hB2C1;
        req = 4'b0011;
        push_round(4'b0011);
        serve_one(1'b0);
        serve_one(1'b0);

        // Watchdog timeout on requester 2.
        uart_mute = 1'b1;
        req_data[23:16] = 8'h9D;
        req = 4'b0100;
        push_round(4'b0100);
        serve_one(1'b1);
        uart_mute = 1'b0;

        // Pointer advanced past 2: requester 3 beats 0 and 1.
        req_data = 32'hF00D_BEEF;
        req = 4'b1011;
        push_round(4'b1011);
        for (int k = 0; k < 3; k++) serve_one(1'b0);

        // Random rounds.
        for (int r = 0; r < 8; r++) begin
            mask     = 4'($urandom_range(1, 15));
            req_data = $urandom();
            req      = mask;
            push_round(mask);
            for (int k = 0; k < 4; k++) begin
                if (mask[k]) serve_one(1'b0);
            end
        end

        // Reset in the middle of WAIT with requester 3 still requesting.
        uart_mute = 1'b1;
        req_data[31:24] = 8'h5C;
        req = 4'b1000;
        for (int n = 0; n < 60 && grant == '0; n++) tick();
        check_eq("rst_test_grant", 32'(grant), 32'h8);
        tick();
        check_eq("rst_test_start", 32'(tx_start), 32'd1);
        repeat (4) tick();
        check_eq("rst_test_in_wait", 32'(dbg_state), 32'd3);
        rst = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rx_q.delete();
        uart_mute = 1'b0;
        rst = 1'b1;
        tick();
        check_init_write("reinit");
        model_ptr = 0;
        push_round(4'b1000);
        serve_one(1'b0);

        check_eq("ctrl_final", 32'(control_data), 32'h03);
        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
